// File: rtl/ldr_pkg.sv
// Shared definitions for the LDR CSR bridge: register map, bit positions,
// FSM state encoding and the unmapped-read marker.
package ldr_pkg;

   localparam logic [7:0] ADDR_CTRL   = 8'h00;
   localparam logic [7:0] ADDR_STATUS = 8'h01;
   localparam logic [7:0] ADDR_CYCLES = 8'h02;
   localparam logic [7:0] ADDR_TMO    = 8'h03;
   localparam logic [7:0] ADDR_ID     = 8'h04;
   localparam logic [7:0] ADDR_R_BASE = 8'h10;
   localparam logic [7:0] ADDR_A_BASE = 8'h40;

   localparam int CTRL_SRST  = 0;
   localparam int CTRL_START = 1;
   localparam int CTRL_IE    = 2;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_OVR  = 2;
   localparam int STAT_TMO  = 3;
   localparam int STAT_WERR = 4;

   typedef logic [1:0] state_t;
   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_RUN  = 2'd1;
   localparam state_t S_DONE = 2'd2;

   localparam logic [15:0] BAD_WORD = 16'h0BAD;

endpackage

// File: rtl/ldr_run_timer.sv
// Run-length counter: cleared on start, counts while running, saturates at
// all-ones and flags when it sits on a non-zero limit.
module ldr_run_timer #(
   parameter int TMO_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             run,
   input  logic [TMO_W-1:0] limit,
   output logic [TMO_W-1:0] cycles,
   output logic             expired
);

   // A zero limit never expires, so the counter then free-runs to saturation.
   assign expired = run && (limit != '0) && (cycles == limit);

   // Count run cycles; stop on the limit so CYCLES reports it after a timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycles <= '0;
      end else if (clear) begin
         cycles <= '0;
      end else if (run && !expired && (cycles != '1)) begin
         cycles <= cycles + TMO_W'(1);
      end
   end

endmodule

// File: rtl/ldr_csr_bridge.sv
// CSR front end for the LDR core: register file, run sequencing, timeout,
// status/irq/led reporting.
//
//  state  | meaning
//  -------+------------------------------------------------------
//  IDLE   | core parked, R writable, waiting for START
//  RUN    | core computing, R frozen, cycle counter running
//  DONE   | result captured into A shadows, waiting for DONE W1C or START
module ldr_csr_bridge
   import ldr_pkg::*;
#(
   parameter int ORDER = 10,
   parameter int DW    = 16,
   parameter int TMO_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              address,
   input  logic                    read,
   input  logic                    write,
   input  logic [DW-1:0]           writedata,
   output logic [DW-1:0]           readdata,
   output logic                    readdatavalid,
   output logic                    irq,
   output logic [7:0]              led,
   output logic                    core_rst,
   output logic                    core_start,
   output logic [(ORDER+1)*DW-1:0] core_r,
   input  logic [(ORDER+1)*DW-1:0] core_a,
   input  logic                    core_done
);

   localparam logic [15:0] ID_WORD = {8'(ORDER), 8'(DW)};

   state_t           state_q, state_d;
   logic             ie_q, done_q, ovr_q, tmo_q, werr_q;
   logic [TMO_W-1:0] tmo_limit_q, cycles;
   logic             timeout;
   logic [DW-1:0]    r_q [ORDER+1];
   logic [DW-1:0]    a_q [ORDER+1];
   logic [ORDER:0]   r_hit, a_hit;
   logic             is_run, wr_ctrl, wr_status, wr_tmo, wr_r;
   logic             srst_req, start_req, go, finish, tmo_hit;
   logic [4:0]       w1c;
   logic [DW-1:0]    rd_mux;

   assign is_run    = (state_q == S_RUN);
   assign wr_ctrl   = write && (address == ADDR_CTRL);
   assign wr_status = write && (address == ADDR_STATUS);
   assign wr_tmo    = write && (address == ADDR_TMO);
   assign wr_r      = write && (|r_hit);
   assign w1c       = wr_status ? writedata[STAT_WERR:0] : 5'b0;
   // SRST outranks everything, including a START in the same write.
   assign srst_req  = wr_ctrl && writedata[CTRL_SRST];
   assign start_req = wr_ctrl && writedata[CTRL_START] && !writedata[CTRL_SRST];
   assign go        = start_req && !is_run;
   // core_done beats both a coincident START and a coincident timeout.
   assign finish    = is_run && core_done && !srst_req;
   assign tmo_hit   = is_run && timeout && !core_done && !srst_req;

   ldr_run_timer #(.TMO_W(TMO_W)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (go),
      .run     (is_run),
      .limit   (tmo_limit_q),
      .cycles  (cycles),
      .expired (timeout)
   );

   // Decode per-coefficient hits for the R and A windows.
   always_comb begin
      r_hit = '0;
      a_hit = '0;
      for (int k = 0; k <= ORDER; k++) begin
         r_hit[k] = (address == ADDR_R_BASE + 8'(k));
         a_hit[k] = (address == ADDR_A_BASE + 8'(k));
      end
   end

   // Next-state logic of the run sequencer.
   always_comb begin
      state_d = state_q;
      if (srst_req) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (go) state_d = S_RUN;
            S_RUN: begin
               if (core_done)    state_d = S_DONE;
               else if (timeout) state_d = S_IDLE;
            end
            S_DONE: begin
               if (go)                  state_d = S_RUN;
               else if (w1c[STAT_DONE]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // FSM, control/status flags and core strobes; hardware sets beat W1C.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ie_q        <= 1'b0;
         done_q      <= 1'b0;
         ovr_q       <= 1'b0;
         tmo_q       <= 1'b0;
         werr_q      <= 1'b0;
         tmo_limit_q <= '0;
         core_start  <= 1'b0;
         core_rst    <= 1'b1;
      end else begin
         state_q    <= state_d;
         core_start <= go;
         core_rst   <= srst_req || tmo_hit;
         if (wr_ctrl) ie_q <= writedata[CTRL_IE];
         if (wr_tmo)  tmo_limit_q <= TMO_W'(writedata);
         done_q <= finish || (done_q && !w1c[STAT_DONE] && !go);
         ovr_q  <= (start_req && is_run) || (ovr_q && !w1c[STAT_OVR]);
         tmo_q  <= tmo_hit || (tmo_q && !w1c[STAT_TMO]);
         werr_q <= (wr_r && is_run) || (werr_q && !w1c[STAT_WERR]);
      end
   end

   // R coefficients (frozen during RUN) and A shadows captured on completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k <= ORDER; k++) begin
            r_q[k] <= '0;
            a_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k <= ORDER; k++) begin
            if (write && r_hit[k] && !is_run) r_q[k] <= writedata;
            if (finish) a_q[k] <= core_a[k*DW +: DW];
         end
      end
   end

   for (genvar k = 0; k <= ORDER; k++) begin : g_core_r
      assign core_r[k*DW +: DW] = r_q[k];
   end

   // Read data selection.
   always_comb begin
      rd_mux = DW'(BAD_WORD);
      if (address == ADDR_CTRL) begin
         rd_mux = '0;
         rd_mux[CTRL_IE] = ie_q;
      end else if (address == ADDR_STATUS) begin
         rd_mux = '0;
         rd_mux[STAT_BUSY] = is_run;
         rd_mux[STAT_DONE] = done_q;
         rd_mux[STAT_OVR]  = ovr_q;
         rd_mux[STAT_TMO]  = tmo_q;
         rd_mux[STAT_WERR] = werr_q;
      end else if (address == ADDR_CYCLES) begin
         rd_mux = DW'(cycles);
      end else if (address == ADDR_TMO) begin
         rd_mux = DW'(tmo_limit_q);
      end else if (address == ADDR_ID) begin
         rd_mux = DW'(ID_WORD);
      end
      for (int k = 0; k <= ORDER; k++) begin
         if (r_hit[k]) rd_mux = r_q[k];
         if (a_hit[k]) rd_mux = a_q[k];
      end
   end

   // Fixed one-cycle read response, zero when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         readdata      <= '0;
         readdatavalid <= 1'b0;
      end else begin
         readdatavalid <= read;
         readdata      <= read ? rd_mux : '0;
      end
   end

   // Registered interrupt and active-low status LEDs.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq <= 1'b0;
         led <= 8'hFF;
      end else begin
         irq <= ie_q && (done_q || tmo_q);
         led <= {4'hF, !(ovr_q || werr_q), !tmo_q, !done_q, !is_run};
      end
   end

endmodule
